// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory: grid geometry, step counter width and FSM states.
package maze_pkg;

   localparam int MAZE_WIDTH = 6;
   localparam int STEP_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SERVE  = 2'd2,
      ST_SOLVED = 2'd3
   } maze_state_e;

endpackage

// File: rtl/maze_bitplane.sv
// One-bit-wide storage plane with a registered read port and a synchronous write port.
module maze_bitplane #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic          wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic          rdata
);

   logic mem_r [0:(2**AW)-1];

   // Write port: storage needs no reset, it is always rewritten before use.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port: data register only updates on a read request.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/maze_mem.sv
// Maze grid memory: serial row-major load of the wall plane, then single-cycle-latency
// solver reads, visited marking, step counting and sticky status flags.
module maze_mem
   import maze_pkg::*;
#(
   parameter int MAZE_WIDTH = maze_pkg::MAZE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic                  load_bit,
   output logic                  load_ready,
   input  logic [MAZE_WIDTH-1:0] row,
   input  logic [MAZE_WIDTH-1:0] col,
   input  logic                  maze_oe,
   input  logic                  maze_we,
   input  logic                  done,
   output logic                  maze_in,
   output logic                  mem_ready,
   output logic [STEP_W-1:0]     step_count,
   output logic                  solved,
   output logic                  wall_err
);

   localparam int              AW        = 2 * MAZE_WIDTH;
   localparam logic [AW-1:0]   ADDR_LAST = {AW{1'b1}};
   localparam logic [AW-1:0]   ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
   localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   maze_state_e       state_r;
   maze_state_e       state_s;
   logic [AW-1:0]     addr_r;
   logic [AW-1:0]     rc_addr_s;
   logic              accept_s;
   logic              serve_s;
   logic              serve_oe_s;
   logic              serve_we_s;
   logic              wall_re_s;
   logic              wall_q_s;
   logic              vis_we_s;
   logic [AW-1:0]     vis_waddr_s;
   logic              vis_rd_unused_s;
   logic              load_ready_r;
   logic              mem_ready_r;
   logic              solved_r;
   logic [STEP_W-1:0] step_r;
   logic              wall_err_r;
   logic              we_pend_r;
   logic              src_wall_r;
   logic              hold_r;

   // load_start has priority over a same-cycle load bit, done or solver write.
   assign rc_addr_s   = {row, col};
   assign serve_s     = (state_r == ST_SERVE);
   assign accept_s    = (state_r == ST_LOAD) & load_valid & ~load_start;
   assign serve_oe_s  = serve_s & maze_oe;
   assign serve_we_s  = serve_s & maze_we & ~load_start;
   assign wall_re_s   = serve_s & (maze_oe | maze_we);
   assign vis_we_s    = accept_s | serve_we_s;
   assign vis_waddr_s = accept_s ? addr_r : rc_addr_s;

   maze_bitplane #(.AW(AW)) u_wall (
      .clk   (clk),
      .we    (accept_s),
      .waddr (addr_r),
      .wdata (load_bit),
      .re    (wall_re_s),
      .raddr (rc_addr_s),
      .rdata (wall_q_s)
   );

   // The load sweep writes 0 to every visited cell before SERVE can be reached.
   maze_bitplane #(.AW(AW)) u_visited (
      .clk   (clk),
      .we    (vis_we_s),
      .waddr (vis_waddr_s),
      .wdata (serve_we_s),
      .re    (serve_oe_s),
      .raddr (rc_addr_s),
      .rdata (vis_rd_unused_s)
   );

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_start) state_s = ST_LOAD;
            else            state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (load_start)                          state_s = ST_LOAD;
            else if (accept_s && addr_r == ADDR_LAST) state_s = ST_SERVE;
            else                                     state_s = ST_LOAD;
         end
         ST_SERVE: begin
            if (load_start) state_s = ST_LOAD;
            else if (done)  state_s = ST_SOLVED;
            else            state_s = ST_SERVE;
         end
         ST_SOLVED: begin
            if (load_start) state_s = ST_LOAD;
            else            state_s = ST_SOLVED;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, load address counter and state-decoded status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         addr_r       <= {AW{1'b0}};
         load_ready_r <= 1'b0;
         mem_ready_r  <= 1'b0;
         solved_r     <= 1'b0;
      end else begin
         state_r      <= state_s;
         load_ready_r <= (state_s == ST_LOAD);
         mem_ready_r  <= (state_s == ST_SERVE) | (state_s == ST_SOLVED);
         solved_r     <= (state_s == ST_SOLVED);
         if (load_start)    addr_r <= {AW{1'b0}};
         else if (accept_s) addr_r <= addr_r + ADDR_ONE;
         else               addr_r <= addr_r;
      end
   end

   // Step counter and wall-hit flag; the wall bit for a write is checked one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_r     <= {STEP_W{1'b0}};
         wall_err_r <= 1'b0;
         we_pend_r  <= 1'b0;
      end else begin
         we_pend_r <= serve_we_s;
         if (load_start)                           step_r <= {STEP_W{1'b0}};
         else if (serve_we_s && step_r != STEP_MAX) step_r <= step_r + STEP_ONE;
         else                                      step_r <= step_r;
         if (load_start)                  wall_err_r <= 1'b0;
         else if (we_pend_r && wall_q_s)  wall_err_r <= 1'b1;
         else                             wall_err_r <= wall_err_r;
      end
   end

   // maze_in source select: live wall read, or a held value when the plane read was
   // only for a write check, or a forced wall for reads outside SERVE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_wall_r <= 1'b0;
         hold_r     <= 1'b1;
      end else if (serve_oe_s) begin
         src_wall_r <= 1'b1;
         hold_r     <= hold_r;
      end else if (maze_oe) begin
         src_wall_r <= 1'b0;
         hold_r     <= 1'b1;
      end else if (wall_re_s) begin
         src_wall_r <= 1'b0;
         hold_r     <= maze_in;
      end else begin
         src_wall_r <= src_wall_r;
         hold_r     <= hold_r;
      end
   end

   assign maze_in    = src_wall_r ? wall_q_s : hold_r;
   assign load_ready = load_ready_r;
   assign mem_ready  = mem_ready_r;
   assign solved     = solved_r;
   assign step_count = step_r;
   assign wall_err   = wall_err_r;

endmodule

// File: doc/maze_mem.md
MAZE_MEM -- requirements
Module: maze_mem

Interface
REQ-001 Parameter MAZE_WIDTH, default 6, SHALL set the row/column index width; the grid is 2^MAZE_WIDTH x 2^MAZE_WIDTH cells.
REQ-002 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port load_start, input, 1, one-cycle pulse that begins a new maze load.
REQ-005 Port load_valid, input, 1, load bit present.
REQ-006 Port load_bit, input, 1, cell value: 1 = wall, 0 = free.
REQ-007 Port load_ready, output, 1, block accepts a load bit this cycle.
REQ-008 Port row, input, MAZE_WIDTH, solver row index.
REQ-009 Port col, input, MAZE_WIDTH, solver column index.
REQ-010 Port maze_oe, input, 1, solver read request.
REQ-011 Port maze_we, input, 1, solver write request (marks the cell visited).
REQ-012 Port done, input, 1, solver reports exit found.
REQ-013 Port maze_in, output, 1, wall bit returned to the solver.
REQ-014 Port mem_ready, output, 1, grid loaded and serving.
REQ-015 Port step_count, output, 16, number of accepted solver writes.
REQ-016 Port solved, output, 1, sticky exit-found flag.
REQ-017 Port wall_err, output, 1, sticky flag: solver wrote to a wall cell.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, SERVE and SOLVED.
REQ-019 IDLE -> LOAD on load_start; LOAD -> SERVE on acceptance of the last cell; SERVE -> SOLVED on done=1; SERVE or SOLVED -> LOAD on load_start.
REQ-020 A load bit SHALL be accepted only when load_valid and load_ready are both 1; load_ready SHALL be 1 only in LOAD.
REQ-021 Accepted bits SHALL be written row-major: a 2*MAZE_WIDTH-bit address counter starts at 0, increments per accepted bit and is reset to 0 on entry to LOAD.
REQ-022 Acceptance at address 2^(2*MAZE_WIDTH)-1 SHALL complete the load; mem_ready SHALL rise the following cycle.
REQ-023 Entering LOAD SHALL clear the visited plane, step_count, solved and wall_err; until cleared, visited bits SHALL read as 0.
REQ-024 In SERVE, maze_oe=1 in cycle t SHALL drive maze_in in cycle t+1 with wall[row][col] sampled at t; maze_in SHALL hold that value until the next read.
REQ-025 maze_oe outside SERVE SHALL make maze_in 1 in the following cycle, so the solver sees a wall.
REQ-026 In SERVE, maze_we=1 SHALL set visited[row][col] and increment step_count, saturating at 16'hFFFF.
REQ-027 If the cell written by maze_we holds a wall, wall_err SHALL be set, the wall bit SHALL stay unchanged, and step_count SHALL still increment.
REQ-028 maze_oe and maze_we in the same cycle: the read returns the wall bit; the visited write proceeds.
REQ-029 maze_we outside SERVE SHALL be ignored.
REQ-030 In SOLVED, solved=1, mem_ready=1, step_count frozen, maze_oe and maze_we ignored.
REQ-031 load_start and done in the same SERVE cycle: load_start wins.
REQ-032 load_start while in LOAD SHALL restart the address counter at 0.

Reset
REQ-033 On rst_n=0: state=IDLE, address=0, load_ready=0, mem_ready=0, maze_in=1, step_count=0, solved=0, wall_err=0.
REQ-034 Wall and visited storage SHALL NOT require reset; visited is cleared per REQ-023.
REQ-035 Reset asserted mid-load or mid-serve SHALL abort to IDLE immediately; a new load_start is required.

Structure
REQ-036 Package maze_pkg SHALL hold MAZE_WIDTH, the FSM state enum and the step counter width (16).
REQ-037 Sub-module maze_bitplane (one 1-bit x 2^(2*MAZE_WIDTH) synchronous-read, synchronous-write array) SHALL be instantiated twice: wall and visited.

Verification
REQ-038 Load 4096 bits with load_valid held at 1, border cells=1, interior=0 -> mem_ready=1 exactly one cycle after the 4096th acceptance; load_ready=0 afterwards.
REQ-039 After the load, oe at (0,5) -> maze_in=1 the next cycle; oe at (10,10) -> maze_in=0.
REQ-040 Three maze_we pulses at free cells, one at wall (0,0) -> step_count=4, wall_err=1, then oe at (0,0) -> maze_in=1.
REQ-041 done pulse in SERVE -> solved=1; a later maze_we leaves step_count unchanged; load_start -> solved=0, step_count=0, load_ready=1.
REQ-042 rst_n low after 100 loaded bits -> IDLE, load_ready=0; load_start, then a full reload -> correct contents readable.
REQ-043 Toggle load_valid at random during the load -> no bits lost or duplicated; a readback of all 4096 cells matches the source pattern.
